// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-port bundle for mem_arbiter
interface mem_arbiter_if #(
   parameter int MEM_DEPTH = 4096
);
   localparam int ADDR_WIDTH = $clog2(MEM_DEPTH * 2);

   logic                  i_if_req;
   logic [ADDR_WIDTH-1:0] i_if_addr;
   logic                  o_if_gnt;
   logic                  o_if_rvalid;
   logic [15:0]           o_if_rdata;

   logic                  i_d_req;
   logic                  i_d_we;
   logic [1:0]            i_d_size;
   logic [ADDR_WIDTH-1:0] i_d_addr;
   logic [31:0]           i_d_wdata;
   logic                  o_d_gnt;
   logic                  o_d_rvalid;
   logic [31:0]           o_d_rdata;
   logic                  o_d_err;

   logic [ADDR_WIDTH-1:0] o_mem_addr;
   logic [15:0]           o_mem_di;
   logic                  o_mem_en;
   logic                  o_mem_rd_en;
   logic [1:0]            o_mem_wr_en;
   logic [15:0]           i_mem_do;

   modport slave (
      input  i_if_req, i_if_addr,
      output o_if_gnt, o_if_rvalid, o_if_rdata,
      input  i_d_req, i_d_we, i_d_size, i_d_addr, i_d_wdata,
      output o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
      output o_mem_addr, o_mem_di, o_mem_en, o_mem_rd_en, o_mem_wr_en,
      input  i_mem_do
   );

   modport master (
      output i_if_req, i_if_addr,
      input  o_if_gnt, o_if_rvalid, o_if_rdata,
      output i_d_req, i_d_we, i_d_size, i_d_addr, i_d_wdata,
      input  o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
      input  o_mem_addr, o_mem_di, o_mem_en, o_mem_rd_en, o_mem_wr_en,
      output i_mem_do
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one 16-bit halfword memory port
module mem_arbiter #(
   parameter int MEM_DEPTH    = 4096,
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   localparam int ADDR_WIDTH = $clog2(MEM_DEPTH * 2);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_WORD2 = 1'b1;

   localparam logic [3:0]            LIMIT    = 4'(STARVE_LIMIT);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_TWO = ADDR_WIDTH'(2);

   logic [0:0]            state_q, state_d;
   logic [3:0]            streak_q, streak_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [15:0]           wdata_lo_q, wdata_lo_d;
   logic                  if_pend_q, if_pend_d;
   logic                  d_pend_q, d_pend_d;
   logic                  d_byte_q, d_byte_d;
   logic                  d_lane_q, d_lane_d;
   logic                  wbeat2_q, wbeat2_d;
   logic [15:0]           hi_q, hi_d;

   logic                  if_gnt, d_gnt, d_err;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [15:0]           mem_di;
   logic                  mem_en, mem_rd_en;
   logic [1:0]            mem_wr_en;

   // Decode of the data request: size 11 behaves as a word
   logic d_word, d_misalign, fetch_win;
   assign d_word     = bus.i_d_size[1];
   assign d_misalign = (d_word && (bus.i_d_addr[1:0] != 2'b00)) ||
                       ((bus.i_d_size == 2'b01) && bus.i_d_addr[0]);
   assign fetch_win  = bus.i_if_req && (!bus.i_d_req || (streak_q == LIMIT));

   // Grant decision, memory port drive and next-state for the two-state FSM
   always_comb begin
      state_d    = state_q;
      streak_d   = streak_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_lo_d = wdata_lo_q;
      if_pend_d  = 1'b0;
      d_pend_d   = 1'b0;
      d_byte_d   = d_byte_q;
      d_lane_d   = d_lane_q;
      wbeat2_d   = 1'b0;
      hi_d       = hi_q;
      if_gnt     = 1'b0;
      d_gnt      = 1'b0;
      d_err      = 1'b0;
      mem_addr   = '0;
      mem_di     = '0;
      mem_en     = 1'b0;
      mem_rd_en  = 1'b0;
      mem_wr_en  = 2'b00;
      if (state_q == S_WORD2) begin
         state_d  = S_IDLE;
         mem_en   = 1'b1;
         mem_addr = addr_q + ADDR_TWO;
         if (we_q) begin
            mem_di    = wdata_lo_q;
            mem_wr_en = 2'b11;
         end else begin
            mem_rd_en = 1'b1;
            hi_d      = bus.i_mem_do;
            wbeat2_d  = 1'b1;
         end
         if (!bus.i_if_req) streak_d = '0;
      end else if (fetch_win) begin
         if_gnt    = 1'b1;
         if_pend_d = 1'b1;
         streak_d  = '0;
         mem_en    = 1'b1;
         mem_rd_en = 1'b1;
         mem_addr  = bus.i_if_addr & ~ADDR_ONE;
      end else if (bus.i_d_req) begin
         d_gnt    = 1'b1;
         streak_d = bus.i_if_req ? streak_q + 4'd1 : 4'd0;
         if (d_misalign) begin
            d_err = 1'b1;
         end else if (d_word) begin
            state_d    = S_WORD2;
            addr_d     = bus.i_d_addr;
            we_d       = bus.i_d_we;
            wdata_lo_d = bus.i_d_wdata[15:0];
            mem_en     = 1'b1;
            mem_addr   = bus.i_d_addr & ~ADDR_TWO;
            if (bus.i_d_we) begin
               mem_di    = bus.i_d_wdata[31:16];
               mem_wr_en = 2'b11;
            end else begin
               mem_rd_en = 1'b1;
            end
         end else begin
            mem_en   = 1'b1;
            mem_addr = bus.i_d_addr;
            if (bus.i_d_we) begin
               if (bus.i_d_size == 2'b00) begin
                  mem_di    = {bus.i_d_wdata[7:0], bus.i_d_wdata[7:0]};
                  mem_wr_en = bus.i_d_addr[0] ? 2'b01 : 2'b10;
               end else begin
                  mem_di    = bus.i_d_wdata[15:0];
                  mem_wr_en = 2'b11;
               end
            end else begin
               mem_rd_en = 1'b1;
               d_pend_d  = 1'b1;
               d_byte_d  = (bus.i_d_size == 2'b00);
               d_lane_d  = bus.i_d_addr[0];
            end
         end
      end else begin
         streak_d = '0;
      end
   end

   // State registers; reset abandons any in-flight word and pending reads
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         streak_q   <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_lo_q <= '0;
         if_pend_q  <= 1'b0;
         d_pend_q   <= 1'b0;
         d_byte_q   <= 1'b0;
         d_lane_q   <= 1'b0;
         wbeat2_q   <= 1'b0;
         hi_q       <= '0;
      end else begin
         state_q    <= state_d;
         streak_q   <= streak_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_lo_q <= wdata_lo_d;
         if_pend_q  <= if_pend_d;
         d_pend_q   <= d_pend_d;
         d_byte_q   <= d_byte_d;
         d_lane_q   <= d_lane_d;
         wbeat2_q   <= wbeat2_d;
         hi_q       <= hi_d;
      end
   end

   // Read data steering; zero whenever no read completes this cycle
   always_comb begin
      bus.o_d_rdata = '0;
      if (wbeat2_q) begin
         bus.o_d_rdata = {hi_q, bus.i_mem_do};
      end else if (d_pend_q) begin
         if (d_byte_q)
            bus.o_d_rdata = {24'h0, d_lane_q ? bus.i_mem_do[7:0] : bus.i_mem_do[15:8]};
         else
            bus.o_d_rdata = {16'h0, bus.i_mem_do};
      end
   end

   assign bus.o_if_rvalid = if_pend_q;
   assign bus.o_if_rdata  = if_pend_q ? bus.i_mem_do : 16'h0;
   assign bus.o_d_rvalid  = d_pend_q | wbeat2_q;

   // Combinational outputs are forced low while reset is held
   assign bus.o_if_gnt    = rst & if_gnt;
   assign bus.o_d_gnt     = rst & d_gnt;
   assign bus.o_d_err     = rst & d_err;
   assign bus.o_mem_en    = rst & mem_en;
   assign bus.o_mem_rd_en = rst & mem_rd_en;
   assign bus.o_mem_wr_en = rst ? mem_wr_en : 2'b00;
   assign bus.o_mem_addr  = rst ? mem_addr : '0;
   assign bus.o_mem_di    = rst ? mem_di : 16'h0;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 16-bit halfword memory port between the instruction-fetch requester and the data (LDR/STR/POP) requester of the pipelined CPU.
- Splits 32-bit data accesses into two halfword beats.
- Performs byte-lane steering for byte and halfword stores and reads.
- Applies data-over-fetch priority with a starvation limit, so fetch always progresses.

Parameters:
- MEM_DEPTH, 4096: memory depth in halfwords. Derived ADDR_WIDTH = clog2(MEM_DEPTH*2), the byte address width.
- STARVE_LIMIT, 4: maximum consecutive data grants while fetch waits (range 1..15).

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_if_req  in  1  fetch request (halfword read)
- i_if_addr  in  ADDR_WIDTH  fetch byte address; bit0 ignored
- o_if_gnt  out  1  fetch accepted this cycle
- o_if_rvalid  out  1  fetch data valid
- o_if_rdata  out  16  fetch data
- i_d_req  in  1  data request
- i_d_we  in  1  1 = write
- i_d_size  in  2  00 byte, 01 halfword, 10 word; 11 is reserved and treated as word
- i_d_addr  in  ADDR_WIDTH  data byte address
- i_d_wdata  in  32  write data, right-aligned
- o_d_gnt  out  1  data request accepted this cycle
- o_d_rvalid  out  1  read data valid
- o_d_rdata  out  32  read data, zero-extended
- o_d_err  out  1  one-cycle pulse: misaligned request rejected
- o_mem_addr  out  ADDR_WIDTH  memory byte address
- o_mem_di  out  16  write data; [15:8] = even byte, [7:0] = odd byte
- o_mem_en  out  1  memory enable
- o_mem_rd_en  out  1  read strobe
- o_mem_wr_en  out  2  byte write enables; bit1 = even byte, bit0 = odd byte
- i_mem_do  in  16  memory read data; valid one cycle after rd_en

Behaviour:
- Reset (rst low, asynchronous):
  - FSM returns to IDLE; streak counter = 0; pending-read tags cleared; hi-half register = 0.
  - All o_* outputs = 0.
  - Any in-flight word access is abandoned; no rvalid is produced for it.
- FSM states: IDLE and WORD2.
  - IDLE: at most one grant per cycle. Memory signals are driven combinationally from the winning requester in the grant cycle T. The requester may change its inputs at T+1.
  - A word grant in IDLE performs beat 1 at T: address addr with bit1 cleared, carrying the upper halfword wdata[31:16]. It latches addr, we and wdata, then moves to WORD2.
  - WORD2 (cycle T+1): performs beat 2 at latched addr+2 with wdata[15:0]. No grant is issued. Next state is IDLE.
- Alignment:
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - A violation in IDLE: o_d_gnt=1, o_d_err=1 for that cycle, no memory access, no rvalid.
  - The cycle is still counted as a data grant for arbitration purposes.
- Arbitration in IDLE:
  - Data wins by default.
  - If i_if_req=1 and the streak counter equals STARVE_LIMIT, fetch wins and the counter clears.
  - The counter increments on each data grant while i_if_req=1, clears on a fetch grant, and clears in any cycle with i_if_req=0.
  - If only one requester is active, it wins.
- Idle memory cycle: o_mem_en=0, rd_en=0, wr_en=00, addr=0, di=0.
- Reads:
  - Every memory read sets en=1, rd_en=1, wr_en=00.
  - Fetch or single-beat data read granted at T: rvalid=1 at T+1, rdata taken directly from i_mem_do.
  - Byte read: rdata = {24'b0, selected byte}, where the lane is picked by latched addr[0] (0 selects [15:8]).
  - Halfword read: rdata = {16'b0, i_mem_do}.
  - Word read: beat-1 data is captured into the hi register at T+1. rvalid=1 at T+2 with rdata = {hi, i_mem_do}.
- Writes:
  - Every write sets en=1, rd_en=0. Writes produce no rvalid.
  - Byte write: di = {wdata[7:0], wdata[7:0]}; wr_en = 10 if addr[0]=0, else 01.
  - Halfword write: di = wdata[15:0]; wr_en = 11.
  - Word write: wr_en = 11 on both beats.
- rvalid and rdata are 0 in all cycles without valid data.
- Back-to-back single-beat grants are allowed every cycle. A read's rvalid may coincide with the next grant.

Test Plan:
- Reset mid-word: assert rst low during WORD2 -> all outputs 0 immediately; no o_d_rvalid afterwards; FSM in IDLE after release.
- Fetch-only stream: i_if_req=1, addr 0x000, 0x002, 0x004 on consecutive cycles with memory returning 0x1111, 0x2222, 0x3333 -> o_if_gnt every cycle; o_if_rvalid one cycle later with those values in order.
- Word read at 0x010, memory 0x010=0xDEAD and 0x012=0xBEEF -> rd_en at addr 0x010 then 0x012; o_d_gnt only in the first cycle; o_d_rvalid at T+2 with 0xDEADBEEF.
- Byte writes: wdata 0x000000A5 to 0x021 -> o_mem_wr_en=01, o_mem_di=0xA5A5. Halfword 0x1234 to 0x022 -> wr_en=11, di=0x1234.
- Starvation, STARVE_LIMIT=4, both requesting continuously -> grant pattern D,D,D,D,F repeating; fetch is never starved beyond 4 cycles.
- Misaligned word to 0x012 -> o_d_gnt=1 and o_d_err=1 for one cycle; o_mem_en=0; no o_d_rvalid. Halfword read at 0x013 -> same error response.
